count_step_sequencer: RTL and testbench

//   Run controller for the +1/+2 step counter datapath: on start, drives the counter from
//   0 to a programmed target using double steps where allowed, without overshooting.

---
 rtl/count_step_sequencer.sv | 110 +++++++++++
 tb/tb_count_step_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/count_step_sequencer.sv
// count_step_sequencer: run controller for a +1/+2 step counter.
// On an accepted start it drives the embedded counter from 0 up to a latched target,
// taking +2 steps when fast mode is latched and at least 2 remain, so the target is
// never overshot. Provides a start/busy/done handshake, level pause and abort.
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous active-high reset, priority over all inputs
//   start    run request, sampled only in IDLE
//   target   final count value, latched on accepted start
//   fast_en  allow +2 steps, latched on accepted start
//   pause    level; holds the count while in RUN
//   abort    ends the current run without done; wins over pause
//   count    counter value (registered)
//   ctrl     step select applied at the next edge (1 = +2, 0 = +1 or no advance)
//   busy     high while in RUN (registered)
//   done     one-cycle pulse on run completion (registered)
//   steps    advance edges taken in the current/last run (registered)
module count_step_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             fast_en,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] steps
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target_q;
    logic             fast_q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] count_next;

    // Distance left to the target; count never exceeds target_q so this cannot underflow.
    assign rem = target_q - count;

    // Step select for the coming edge; only a real advance in RUN can be a double step.
    assign ctrl = (state == S_RUN) && !abort && !pause && fast_q && (rem >= WIDTH'(2));

    // A double step is only chosen with rem >= 2, so the sum never wraps.
    assign count_next = count + (ctrl ? WIDTH'(2) : WIDTH'(1));

    // Run state machine with registered count, steps and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            target_q <= '0;
            fast_q   <= 1'b0;
            count    <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target_q <= target;
                        fast_q   <= fast_en;
                        count    <= '0;
                        steps    <= '0;
                        if (target == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (!pause) begin
                        count <= count_next;
                        steps <= steps + WIDTH'(1);
                        if (count_next == target_q) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_step_sequencer.sv
// Self-checking bench for count_step_sequencer: a reference model predicts the
// registered outputs for every edge and queues them; they are popped and compared
// after the edge. ctrl is compared directly against the model before each edge.
module tb_count_step_sequencer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] target;
    logic             fast_en;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             ctrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] steps;

    count_step_sequencer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .target  (target),
        .fast_en (fast_en),
        .pause   (pause),
        .abort   (abort),
        .count   (count),
        .ctrl    (ctrl),
        .busy    (busy),
        .done    (done),
        .steps   (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int count;
        int busy;
        int done;
        int steps;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model: 0 idle, 1 run, 2 done
    int m_state = 0;
    int m_count = 0;
    int m_steps = 0;
    int m_tq    = 0;
    int m_fq    = 0;
    bit m_valid = 1'b0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: check ctrl, advance the model, queue its prediction, compare after the edge.
    task automatic cycle();
        exp_t e;
        exp_t g;
        int   exp_ctrl;
        int   inc;
        #2;
        if (m_valid) begin
            exp_ctrl = (m_state == 1 && !abort && !pause && m_fq != 0 && (m_tq - m_count) >= 2) ? 1 : 0;
            check_val("ctrl", int'(ctrl), exp_ctrl);
        end
        if (rst) begin
            m_state = 0; m_count = 0; m_steps = 0; m_tq = 0; m_fq = 0;
        end else begin
            case (m_state)
                0: if (start) begin
                    m_tq = int'(target); m_fq = int'(fast_en); m_count = 0; m_steps = 0;
                    m_state = (target == 0) ? 2 : 1;
                end
                1: if (abort) begin
                    m_state = 0;
                end else if (!pause) begin
                    inc = (m_fq != 0 && (m_tq - m_count) >= 2) ? 2 : 1;
                    m_count += inc;
                    m_steps += 1;
                    if (m_count == m_tq) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
        e.count = m_count;
        e.busy  = (m_state == 1) ? 1 : 0;
        e.done  = (m_state == 2) ? 1 : 0;
        e.steps = m_steps;
        exp_q.push_back(e);
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check_val("count", int'(count), g.count);
        check_val("busy",  int'(busy),  g.busy);
        check_val("done",  int'(done),  g.done);
        check_val("steps", int'(steps), g.steps);
    endtask

    // Launch one run and follow it until the model is idle again.
    task automatic run_case(input string tag, input int t, input int f,
                            input int pause_at, input int pause_len, input int abort_at,
                            input int restart_at, input int exp_steps, input int exp_count,
                            input int exp_done_edge, input int exp_busy_cycles, input int exp_ctrl_hist);
        int edge_idx    = 0;
        int done_edge   = -1;
        int done_pulses = 0;
        int busy_cycles = 0;
        int paused      = 0;
        int ctrl_hist   = 0;
        int budget      = 0;
        start = 1'b1; target = WIDTH'(t); fast_en = f[0]; pause = 1'b0; abort = 1'b0;
        cycle();
        if (done) begin done_edge = edge_idx; done_pulses++; end
        if (busy) busy_cycles++;
        start = 1'b0; target = '0; fast_en = 1'b0;
        while (m_state != 0 && budget < 40) begin
            budget++;
            edge_idx++;
            pause = (m_state == 1 && m_count == pause_at && paused < pause_len) ? 1'b1 : 1'b0;
            if (pause) paused++;
            abort = (m_state == 1 && m_count == abort_at) ? 1'b1 : 1'b0;
            start = (m_state == 1 && m_count == restart_at) ? 1'b1 : 1'b0;
            if (start) begin target = 4'd3; fast_en = 1'b0; end
            #2;
            if (m_state == 1 && !pause && !abort) ctrl_hist = (ctrl_hist << 1) | int'(ctrl);
            #(-0);
            cycle();
            if (done) begin done_edge = edge_idx; done_pulses++; end
            if (busy) busy_cycles++;
            start = 1'b0; pause = 1'b0; abort = 1'b0; target = '0;
        end
        check_val({tag, " timeout"}, (budget < 40) ? 1 : 0, 1);
        check_val({tag, " steps"}, int'(steps), exp_steps);
        check_val({tag, " final_count"}, int'(count), exp_count);
        check_val({tag, " done_edge"}, done_edge, exp_done_edge);
        check_val({tag, " done_pulses"}, done_pulses, (exp_done_edge >= 0) ? 1 : 0);
        check_val({tag, " busy_cycles"}, busy_cycles, exp_busy_cycles);
        check_val({tag, " ctrl_hist"}, ctrl_hist, exp_ctrl_hist);
        check_val({tag, " busy_after"}, int'(busy), 0);
        // one idle cycle with start low: outputs hold, no stray done
        cycle();
        check_val({tag, " idle_hold"}, int'(count), exp_count);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; target = '0; fast_en = 1'b0; pause = 1'b0; abort = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        check_val("reset count", int'(count), 0);
        check_val("reset steps", int'(steps), 0);
        check_val("reset busy",  int'(busy), 0);
        check_val("reset done",  int'(done), 0);
        check_val("reset ctrl",  int'(ctrl), 0);
        rst = 1'b0;
        cycle();

        //        tag    T  f  pause  len abort restart steps cnt dedge busy ctrl_hist
        run_case("t5f",  5, 1, -1,    0,  -1,   -1,     3,    5,  3,    3,   3'b110);
        run_case("t5s",  5, 0, -1,    0,  -1,   -1,     5,    5,  5,    5,   0);
        run_case("t0",   0, 1, -1,    0,  -1,   -1,     0,    0,  0,    0,   0);
        run_case("t6p",  6, 1, 2,     2,  -1,   -1,     3,    6,  5,    5,   3'b111);
        run_case("t15a", 15, 1, -1,   0,  4,    2,      2,    4, -1,    3,   2'b11);
        run_case("t15f", 15, 1, -1,   0,  -1,   -1,     8,   15,  8,    8,   8'hFE);

        // reset in the middle of a new run
        start = 1'b1; target = 4'd15; fast_en = 1'b1;
        cycle();
        start = 1'b0; target = '0; fast_en = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check_val("pre_rst busy", int'(busy), 1);
        rst = 1'b1;
        cycle();
        check_val("rst count", int'(count), 0);
        check_val("rst steps", int'(steps), 0);
        check_val("rst busy",  int'(busy), 0);
        check_val("rst done",  int'(done), 0);
        rst = 1'b0;
        cycle();
        check_val("post_rst ctrl", int'(ctrl), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
